parking_gate_arbiter: RTL and testbench

Single-lane gate controller for the parking lot. Entry and exit traffic share one physical gate lane. The block arbitrates between entry and exit requests and opens the gate for one direction at a time. It tracks occupancy against a capacity limit and closes the gate on completion, abort or timeout. It sits between the sensor-decoding FSMs (which produce requests and pass/abort pulses) and the occupancy display / gate actuator logic.

---
 rtl/parking_gate_arbiter_pkg.sv | 19 +
 rtl/parking_gate_arbiter_gate_timer.sv | 35 +++
 rtl/parking_gate_arbiter.sv | 129 ++++++++++++
 tb/tb_parking_gate_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types for the parking gate arbiter: FSM state encoding, service
// direction and the default lot capacity.
package parking_pkg;

    localparam int DEFAULT_CAPACITY = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTER_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2,
        COOLDOWN   = 2'd3
    } gate_state_t;

    typedef enum logic {
        DIR_ENTER = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

endpackage

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Gate-open watchdog: counts cycles while enabled and flags the last allowed
// cycle combinationally so the FSM can close on the following edge.
module gate_timer
    import parking_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST_C = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_r;

    // Cycle counter; holds at the last value instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= '0;
        end else if (clear) begin
            timer_r <= '0;
        end else if (en && (timer_r != LAST_C)) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    assign expired = (timer_r == LAST_C);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single-lane parking gate arbiter: round-robin entry/exit grant, occupancy
// counting against capacity, and close-on-pass/abort/timeout sequencing.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int CNT_W    = 5,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enter_req,
    input  logic             exit_req,
    input  logic             pass_done,
    input  logic             abort,
    output logic             grant_enter,
    output logic             grant_exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    gate_state_t      state_r, next_state_s;
    dir_t             last_served_r, last_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             grant_enter_r, grant_exit_r, timeout_err_r;
    logic             tmo_next_s;
    logic             elig_enter_s, elig_exit_s;
    logic             open_s, expired_s;

    assign full         = (count_r == CAP_C);
    assign empty        = (count_r == '0);
    assign elig_enter_s = enter_req && !full;
    assign elig_exit_s  = exit_req && !empty;
    assign open_s       = (state_r == ENTER_OPEN) || (state_r == EXIT_OPEN);

    gate_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!open_s),
        .en      (open_s),
        .expired (expired_s)
    );

    // Next-state, occupancy and round-robin decisions.
    always_comb begin
        next_state_s = state_r;
        count_next_s = count_r;
        last_next_s  = last_served_r;
        tmo_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // Entry wins unless exit is also eligible and entry went last.
                if (elig_enter_s && (!elig_exit_s || (last_served_r == DIR_EXIT))) begin
                    next_state_s = ENTER_OPEN;
                    last_next_s  = DIR_ENTER;
                end else if (elig_exit_s) begin
                    next_state_s = EXIT_OPEN;
                    last_next_s  = DIR_EXIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ENTER_OPEN: begin
                if (pass_done) begin
                    count_next_s = count_r + ONE_C;
                    next_state_s = COOLDOWN;
                end else if (abort) begin
                    next_state_s = COOLDOWN;
                end else if (expired_s) begin
                    tmo_next_s   = 1'b1;
                    next_state_s = COOLDOWN;
                end else begin
                    next_state_s = ENTER_OPEN;
                end
            end
            EXIT_OPEN: begin
                if (pass_done) begin
                    count_next_s = count_r - ONE_C;
                    next_state_s = COOLDOWN;
                end else if (abort) begin
                    next_state_s = COOLDOWN;
                end else if (expired_s) begin
                    tmo_next_s   = 1'b1;
                    next_state_s = COOLDOWN;
                end else begin
                    next_state_s = EXIT_OPEN;
                end
            end
            COOLDOWN: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            last_served_r <= DIR_EXIT;
            count_r       <= '0;
            grant_enter_r <= 1'b0;
            grant_exit_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            last_served_r <= last_next_s;
            count_r       <= count_next_s;
            grant_enter_r <= (next_state_s == ENTER_OPEN);
            grant_exit_r  <= (next_state_s == EXIT_OPEN);
            timeout_err_r <= tmo_next_s;
        end
    end

    assign grant_enter = grant_enter_r;
    assign grant_exit  = grant_exit_r;
    assign count       = count_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter (TIMEOUT shortened to 8).
module tb_parking_gate_arbiter;

    logic       clk;
    logic       reset_n;
    logic       enter_req, exit_req, pass_done, abort;
    logic       grant_enter, grant_exit, full, empty, timeout_err;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    parking_gate_arbiter #(
        .CAPACITY (16),
        .CNT_W    (5),
        .TIMEOUT  (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enter_req   (enter_req),
        .exit_req    (exit_req),
        .pass_done   (pass_done),
        .abort       (abort),
        .grant_enter (grant_enter),
        .grant_exit  (grant_exit),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, and check grant exclusivity.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("grant_overlap", 32'(grant_enter & grant_exit), 32'd0);
    endtask

    // One complete pass in the given direction (0 = entry, 1 = exit).
    task automatic do_pass(input bit dir);
        if (dir) exit_req = 1'b1; else enter_req = 1'b1;
        tick();
        chk(dir ? "pass_grant_exit" : "pass_grant_enter",
            32'(dir ? grant_exit : grant_enter), 32'd1);
        enter_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        exp_count = dir ? exp_count - 1 : exp_count + 1;
        chk("pass_count", 32'(count), 32'(exp_count));
        chk("pass_closed", 32'(grant_enter | grant_exit), 32'd0);
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        enter_req = 1'b0;
        exit_req  = 1'b0;
        pass_done = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_enter", 32'(grant_enter), 32'd0);
        chk("rst_grant_exit",  32'(grant_exit),  32'd0);
        chk("rst_count",       32'(count),       32'd0);
        chk("rst_empty",       32'(empty),       32'd1);
        chk("rst_full",        32'(full),        32'd0);
        chk("rst_timeout",     32'(timeout_err), 32'd0);
        reset_n = 1'b1;

        // Basic entry: grant one cycle after request, count after pass.
        tick();
        enter_req = 1'b1;
        tick();
        chk("t1_grant", 32'(grant_enter), 32'd1);
        enter_req = 1'b0;
        tick();
        chk("t1_grant_hold", 32'(grant_enter), 32'd1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        exp_count = 1;
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_grant_off", 32'(grant_enter), 32'd0);
        tick();
        chk("t1_idle_closed", 32'(grant_enter | grant_exit), 32'd0);

        // Reach count 3 with exit served last, so entry wins the next tie.
        do_pass(1'b0);
        do_pass(1'b0);
        do_pass(1'b0);
        do_pass(1'b1);
        chk("t2_setup", 32'(count), 32'd3);

        // Both requests held: entry, then exit, with closed cycles between.
        enter_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        chk("t2_rr_enter", 32'(grant_enter), 32'd1);
        chk("t2_rr_no_exit", 32'(grant_exit), 32'd0);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        chk("t2_count_up", 32'(count), 32'd4);
        chk("t2_gap1", 32'(grant_enter | grant_exit), 32'd0);
        tick();
        chk("t2_gap2", 32'(grant_enter | grant_exit), 32'd0);
        tick();
        chk("t2_rr_exit", 32'(grant_exit), 32'd1);
        chk("t2_rr_no_enter", 32'(grant_enter), 32'd0);
        enter_req = 1'b0;
        exit_req  = 1'b0;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        chk("t2_count_down", 32'(count), 32'd3);
        tick();
        exp_count = 3;

        // Fill the lot.
        for (int i = 0; i < 13; i++) do_pass(1'b0);
        chk("t3_count_full", 32'(count), 32'd16);
        chk("t3_full", 32'(full), 32'd1);
        enter_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("t3_no_grant_full", 32'(grant_enter), 32'd0);
        end
        enter_req = 1'b0;
        do_pass(1'b1);
        chk("t3_count_15", 32'(count), 32'd15);
        chk("t3_not_full", 32'(full), 32'd0);

        // Drain to empty; exit must then be refused.
        for (int i = 0; i < 15; i++) do_pass(1'b1);
        chk("t4_empty", 32'(empty), 32'd1);
        exit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_no_grant_empty", 32'(grant_exit), 32'd0);
        end
        exit_req = 1'b0;
        chk("t4_still_empty", 32'(empty), 32'd1);

        // Abort during entry.
        enter_req = 1'b1;
        tick();
        chk("t4_abort_grant", 32'(grant_enter), 32'd1);
        enter_req = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_closed", 32'(grant_enter), 32'd0);
        chk("t4_abort_count", 32'(count), 32'd0);
        tick();

        // Timeout: 8 cycles after grant rises.
        enter_req = 1'b1;
        tick();
        chk("t5_grant", 32'(grant_enter), 32'd1);
        enter_req = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t5_open", 32'(grant_enter), 32'd1);
            chk("t5_no_tmo_yet", 32'(timeout_err), 32'd0);
        end
        tick();
        chk("t5_tmo_pulse", 32'(timeout_err), 32'd1);
        chk("t5_tmo_closed", 32'(grant_enter), 32'd0);
        chk("t5_tmo_count", 32'(count), 32'd0);
        tick();
        chk("t5_tmo_single", 32'(timeout_err), 32'd0);

        // pass_done in the expiry cycle beats the timeout.
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        chk("t5_pre_expiry_open", 32'(grant_enter), 32'd1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        chk("t5_expiry_pass_count", 32'(count), 32'd1);
        chk("t5_expiry_no_tmo", 32'(timeout_err), 32'd0);
        tick();

        // pass_done together with abort counts once.
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
        pass_done = 1'b1;
        abort     = 1'b1;
        tick();
        pass_done = 1'b0;
        abort     = 1'b0;
        chk("t5_both_count", 32'(count), 32'd2);
        tick();
        exp_count = 2;

        // Async reset during exit service with count 5.
        do_pass(1'b0);
        do_pass(1'b0);
        do_pass(1'b0);
        chk("t6_setup", 32'(count), 32'd5);
        exit_req = 1'b1;
        tick();
        chk("t6_grant_exit", 32'(grant_exit), 32'd1);
        exit_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant_exit), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        chk("t6_late_pass_count", 32'(count), 32'd0);
        chk("t6_late_pass_grants", 32'(grant_enter | grant_exit), 32'd0);
        tick();
        chk("t6_final_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
